uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width, parity, stop bits and bit period. Uses a 2-FF synchroniser with 3-sample majority vote and detects parity, framing, break and overrun errors. Delivers each character through a one-entry valid/ready holding register to the levitator command parser, at 50 MHz with a default of 390625 baud (128 clocks per bit).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync_vote.sv | 35 +++
 rtl/uart_rx_cfg.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
//==============================================================================
// uart_pkg : shared constants and FSM encoding for the configurable UART receiver
// Revision  : 1.0
//==============================================================================
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 50 MHz clock / 390625 baud
  localparam int CLKS_PER_BIT_DEFAULT = 128;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync_vote.sv
`default_nettype none
//==============================================================================
// uart_rx_sync_vote : 2-FF line synchroniser with 3-sample majority vote
// Revision          : 1.0
//==============================================================================
module uart_rx_sync_vote (
  input  logic clock_in,
  input  logic reset_in,
  input  logic i_serial,
  output logic o_synced,
  output logic o_vote
);

  logic       r_meta;
  logic       r_sync;
  logic [2:0] r_hist;

  // Everything resets to the idle (high) line level.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 3'b111;
    end else begin
      r_meta <= i_serial;
      r_sync <= r_meta;
      r_hist <= {r_hist[1:0], r_sync};
    end
  end

  assign o_synced = r_sync;
  assign o_vote   = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

endmodule : uart_rx_sync_vote
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
//==============================================================================
// uart_rx_cfg : parametrised UART receiver with error flags and valid/ready hold
// Revision    : 1.0
//==============================================================================
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 RX_serial,
  output logic [DATA_BITS-1:0] output_RX_byte,
  output logic                 output_RX_valid,
  input  logic                 RX_ready,
  output logic                 output_RX_parity_err,
  output logic                 output_RX_frame_err,
  output logic                 output_RX_break,
  output logic                 output_RX_overrun
);

  localparam int                 c_cnt_w      = $clog2(CLKS_PER_BIT);
  localparam int                 c_idx_w      = 4;
  localparam logic [c_cnt_w-1:0] c_cnt_half   = c_cnt_w'(CLKS_PER_BIT / 2);
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_data_last  = c_idx_w'(DATA_BITS - 1);
  localparam logic [c_idx_w-1:0] c_stop_last  = c_idx_w'(STOP_BITS - 1);
  localparam logic               c_has_parity = (PARITY_MODE != PARITY_NONE);
  localparam logic               c_odd        = (PARITY_MODE == PARITY_ODD);

  logic w_synced;
  logic w_vote;

  uart_rx_sync_vote u_sync_vote (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .i_serial (RX_serial),
    .o_synced (w_synced),
    .o_vote   (w_vote)
  );

  rx_state_t            r_state, w_state_next;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
  logic [c_idx_w-1:0]   r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_par_bit, w_par_bit_next;
  logic                 r_par_err, w_par_err_next;
  logic                 r_ferr, w_ferr_next;
  logic                 w_done;
  logic                 w_ferr_now;
  logic                 w_brk_now;

  // Frame status as it stands at the current stop-bit sample.
  assign w_ferr_now = r_ferr | ~w_vote;
  assign w_brk_now  = w_ferr_now && (r_shift == '0) && !r_par_bit;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_err <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
      r_par_bit <= w_par_bit_next;
      r_par_err <= w_par_err_next;
      r_ferr    <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_par_bit_next = r_par_bit;
    w_par_err_next = r_par_err;
    w_ferr_next    = r_ferr;
    w_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next     = '0;
        w_idx_next     = '0;
        w_par_bit_next = 1'b0;
        w_par_err_next = 1'b0;
        w_ferr_next    = 1'b0;
        if (!w_synced) w_state_next = ST_START;
      end
      ST_START: begin
        if (r_cnt == c_cnt_half) begin
          w_cnt_next   = '0;
          w_state_next = w_vote ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_next   = '0;
          w_shift_next = {w_vote, r_shift[DATA_BITS-1:1]};
          if (r_idx == c_data_last) begin
            w_idx_next   = '0;
            w_state_next = c_has_parity ? ST_PARITY : ST_STOP;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_next     = '0;
          w_par_bit_next = w_vote;
          w_par_err_next = ((^r_shift) ^ w_vote) != c_odd;
          w_state_next   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_next  = '0;
          w_ferr_next = w_ferr_now;
          if (r_idx == c_stop_last) begin
            w_done       = 1'b1;
            w_idx_next   = '0;
            // A low stop bit means the line may still be held low; wait it out.
            w_state_next = w_ferr_now ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        w_cnt_next = '0;
        if (w_synced) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  logic                 w_hs;
  logic [DATA_BITS-1:0] r_byte;
  logic                 r_valid;
  logic                 r_perr_out;
  logic                 r_ferr_out;
  logic                 r_brk_out;
  logic                 r_ovr_out;

  assign w_hs = r_valid & RX_ready;

  // One-entry holding register; a completion during handshake replaces the entry.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_brk_out  <= 1'b0;
      r_ovr_out  <= 1'b0;
    end else begin
      if (w_done && (!r_valid || w_hs)) begin
        r_byte     <= r_shift;
        r_valid    <= 1'b1;
        r_perr_out <= r_par_err;
        r_ferr_out <= w_ferr_now;
        r_brk_out  <= w_brk_now;
      end else if (w_hs) begin
        r_valid    <= 1'b0;
        r_perr_out <= 1'b0;
        r_ferr_out <= 1'b0;
        r_brk_out  <= 1'b0;
      end
      if (w_done && r_valid && !w_hs) r_ovr_out <= 1'b1;
      else if (w_hs)                  r_ovr_out <= 1'b0;
    end
  end

  assign output_RX_byte       = r_byte;
  assign output_RX_valid      = r_valid;
  assign output_RX_parity_err = r_perr_out;
  assign output_RX_frame_err  = r_ferr_out;
  assign output_RX_break      = r_brk_out;
  assign output_RX_overrun    = r_ovr_out;

endmodule : uart_rx_cfg
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
//==============================================================================
// tb_uart_rx_cfg : directed scoreboard bench for uart_rx_cfg (8N1 and 8E1 instances)
// Revision       : 1.0
//==============================================================================
module tb_uart_rx_cfg;

  localparam int CPB     = 128;
  localparam int WIN_8N1 = 10 * CPB + 16;
  localparam int WIN_8E1 = 11 * CPB + 16;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ready = 1'b1;
  logic rx0   = 1'b1;
  logic rx1   = 1'b1;

  logic [7:0] byte0, byte1;
  logic valid0, perr0, ferr0, brk0, ovr0;
  logic valid1, perr1, ferr1, brk1, ovr1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clock_in             (clk),
    .reset_in             (rst),
    .RX_serial            (rx0),
    .output_RX_byte       (byte0),
    .output_RX_valid      (valid0),
    .RX_ready             (ready),
    .output_RX_parity_err (perr0),
    .output_RX_frame_err  (ferr0),
    .output_RX_break      (brk0),
    .output_RX_overrun    (ovr0)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .clock_in             (clk),
    .reset_in             (rst),
    .RX_serial            (rx1),
    .output_RX_byte       (byte1),
    .output_RX_valid      (valid1),
    .RX_ready             (ready),
    .output_RX_parity_err (perr1),
    .output_RX_frame_err  (ferr1),
    .output_RX_break      (brk1),
    .output_RX_overrun    (ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 1) rx1 = v;
    else          rx0 = v;
  endtask

  task automatic hold_bit();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    set_rx(sel, 1'b0);
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      hold_bit();
    end
    if (has_par) begin
      set_rx(sel, par);
      hold_bit();
    end
    set_rx(sel, stop);
    hold_bit();
    set_rx(sel, 1'b1);
  endtask

  // Counts valid rises over ncyc cycles and checks each new character against the scoreboard.
  task automatic watch(input int sel, input int ncyc, output int nrise, output int nhigh,
                       output int lat);
    logic prev, v;
    exp_t e, obs;
    nrise = 0;
    nhigh = 0;
    lat   = -1;
    prev  = (sel == 1) ? valid1 : valid0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      v = (sel == 1) ? valid1 : valid0;
      if (v) nhigh++;
      if (v && !prev) begin
        nrise++;
        if (lat < 0) lat = k;
        obs = (sel == 1) ? {byte1, perr1, ferr1, brk1} : {byte0, perr0, ferr0, brk0};
        chk("sb_entry_available", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("char_byte", 32'(obs.b), 32'(e.b));
          chk("char_parity_err", 32'(obs.pe), 32'(e.pe));
          chk("char_frame_err", 32'(obs.fe), 32'(e.fe));
          chk("char_break", 32'(obs.brk), 32'(e.brk));
        end
      end
      prev = v;
    end
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nr, nh, lat;

    repeat (5) @(negedge clk);
    chk("reset_dut0_outputs", 32'({valid0, byte0, perr0, ferr0, brk0, ovr0}), 0);
    chk("reset_dut1_outputs", 32'({valid1, byte1, perr1, ferr1, brk1, ovr1}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xF5, ready high: single-cycle valid, latency about 1220 cycles
    sb.push_back('{b: 8'hF5, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    fork
      send_frame(0, 8'hF5, 1'b0, 1'b0, 1'b1);
      watch(0, WIN_8N1, nr, nh, lat);
    join
    chk("f5_valid_count", nr, 1);
    chk("f5_valid_high_cycles", nh, 1);
    chk("f5_latency_1219_to_1221", 32'(lat >= 1219 && lat <= 1221), 1);

    // Even parity: 0x07 has three ones
    sb.push_back('{b: 8'h07, pe: 1'b1, fe: 1'b0, brk: 1'b0});
    fork
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
      watch(1, WIN_8E1, nr, nh, lat);
    join
    chk("par0_valid_count", nr, 1);
    sb.push_back('{b: 8'h07, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    fork
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      watch(1, WIN_8E1, nr, nh, lat);
    join
    chk("par1_valid_count", nr, 1);

    // Short start glitch is rejected, next frame still received
    rx0 = 1'b0;
    repeat (40) @(negedge clk);
    rx0 = 1'b1;
    watch(0, 400, nr, nh, lat);
    chk("glitch_no_valid", nr, 0);
    sb.push_back('{b: 8'h3C, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    fork
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
      watch(0, WIN_8N1, nr, nh, lat);
    join
    chk("after_glitch_valid_count", nr, 1);

    // Low stop bit on non-zero data: framing error, not a break
    sb.push_back('{b: 8'h81, pe: 1'b0, fe: 1'b1, brk: 1'b0});
    fork
      send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
      watch(0, WIN_8N1, nr, nh, lat);
    join
    chk("frame_err_valid_count", nr, 1);

    // Line held low for two frame times: exactly one break character
    sb.push_back('{b: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1});
    rx0 = 1'b0;
    watch(0, 20 * CPB, nr, nh, lat);
    chk("break_valid_count", nr, 1);
    rx0 = 1'b1;
    watch(0, 400, nr, nh, lat);
    chk("after_break_no_valid", nr, 0);

    // Overrun: second character dropped while the first is held
    ready = 1'b0;
    sb.push_back('{b: 8'h11, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    fork
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
      watch(0, WIN_8N1, nr, nh, lat);
    join
    chk("ovr_first_valid_count", nr, 1);
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
      watch(0, WIN_8N1, nr, nh, lat);
    join
    chk("ovr_no_new_rise", nr, 0);
    chk("ovr_valid_held", 32'(valid0), 1);
    chk("ovr_byte_kept", 32'(byte0), 32'h11);
    chk("ovr_flag_set", 32'(ovr0), 1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("ovr_valid_dropped", 32'(valid0), 0);
    chk("ovr_flag_cleared", 32'(ovr0), 0);

    // Reset in the middle of a frame clears held outputs at once
    sb.push_back('{b: 8'h33, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    fork
      send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
      watch(0, WIN_8N1, nr, nh, lat);
    join
    chk("pre_reset_valid_count", nr, 1);
    chk("pre_reset_valid_held", 32'(valid0), 1);
    rx0 = 1'b0;
    hold_bit();
    for (int i = 0; i < 4; i++) begin
      rx0 = i[0];
      hold_bit();
    end
    rst = 1'b1;
    #1;
    chk("midframe_reset_outputs", 32'({valid0, byte0, perr0, ferr0, brk0, ovr0}), 0);
    @(negedge clk);
    rx0 = 1'b1;
    repeat (10) @(negedge clk);
    rst   = 1'b0;
    ready = 1'b1;
    repeat (20) @(negedge clk);
    sb.push_back('{b: 8'h55, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    fork
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
      watch(0, WIN_8N1, nr, nh, lat);
    join
    chk("post_reset_valid_count", nr, 1);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_cfg
`default_nettype wire
